// File: rtl/layer_sequencer.sv
// Layer sequencer: walks the per-layer descriptor table, drives the shared cfg bus
// and launches one engine per layer, reporting progress, completion and errors.
module layer_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int DIM_W   = 16,
  parameter int NUM_ENG = 4,
  parameter int ENG_W   = 2,
  parameter int LAYER_W = 8,
  parameter int TMO_W   = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [LAYER_W-1:0] cfg_num_layers,
  input  logic [TMO_W-1:0]   cfg_timeout,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [2:0]         err_code,
  output logic [LAYER_W-1:0] cur_layer,
  output logic               desc_rd_en,
  output logic [LAYER_W-1:0] desc_rd_addr,
  input  logic [ENG_W-1:0]   desc_op,
  input  logic [DIM_W-1:0]   desc_in_h,
  input  logic [DIM_W-1:0]   desc_in_w,
  input  logic [DIM_W-1:0]   desc_in_c,
  input  logic [ADDR_W-1:0]  desc_in_base,
  input  logic [ADDR_W-1:0]  desc_out_base,
  output logic [NUM_ENG-1:0] eng_start,
  input  logic [NUM_ENG-1:0] eng_busy,
  input  logic [NUM_ENG-1:0] eng_done,
  output logic [DIM_W-1:0]   cfg_in_h,
  output logic [DIM_W-1:0]   cfg_in_w,
  output logic [DIM_W-1:0]   cfg_in_c,
  output logic [ADDR_W-1:0]  cfg_in_base,
  output logic [ADDR_W-1:0]  cfg_out_base
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_FETCH = 4'd1;
  localparam logic [3:0] S_LATCH = 4'd2;
  localparam logic [3:0] S_CHECK = 4'd3;
  localparam logic [3:0] S_START = 4'd4;
  localparam logic [3:0] S_WAIT  = 4'd5;
  localparam logic [3:0] S_NEXT  = 4'd6;
  localparam logic [3:0] S_DONE  = 4'd7;
  localparam logic [3:0] S_ERR   = 4'd8;

  localparam logic [2:0] E_NONE     = 3'd0;
  localparam logic [2:0] E_BAD_OP   = 3'd1;
  localparam logic [2:0] E_TIMEOUT  = 3'd2;
  localparam logic [2:0] E_SPURIOUS = 3'd3;
  localparam logic [2:0] E_ABORT    = 3'd4;

  logic [3:0]         state;
  logic [LAYER_W-1:0] num_layers;
  logic [TMO_W-1:0]   tmo_limit;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [ENG_W-1:0]   op;
  logic [NUM_ENG-1:0] op_mask;
  logic               op_done;
  logic               spurious;
  logic               tmo_hit;

  // An op beyond the engine bank shifts the bit out entirely, so an all-zero mask flags a bad op.
  assign op_mask  = NUM_ENG'(1) << op;
  assign op_done  = |(eng_done & op_mask);
  assign spurious = |(eng_done & ~op_mask);
  assign tmo_hit  = (tmo_limit != '0) && (tmo_cnt == tmo_limit);

  assign busy         = (state != S_IDLE);
  assign desc_rd_en   = (state == S_FETCH);
  assign desc_rd_addr = cur_layer;
  assign eng_start    = (state == S_START && !abort) ? op_mask : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      num_layers   <= '0;
      tmo_limit    <= '0;
      tmo_cnt      <= '0;
      op           <= '0;
      cur_layer    <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= E_NONE;
      cfg_in_h     <= '0;
      cfg_in_w     <= '0;
      cfg_in_c     <= '0;
      cfg_in_base  <= '0;
      cfg_out_base <= '0;
    end else begin
      done <= 1'b0;
      // Abort overrides everything once a sequence is running; S_ERR is already terminating.
      if (abort && state != S_IDLE && state != S_ERR) begin
        err_code <= E_ABORT;
        state    <= S_ERR;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              num_layers <= cfg_num_layers;
              tmo_limit  <= cfg_timeout;
              cur_layer  <= '0;
              error      <= 1'b0;
              err_code   <= E_NONE;
              state      <= (cfg_num_layers == '0) ? S_DONE : S_FETCH;
            end
          end
          S_FETCH: state <= S_LATCH;
          S_LATCH: begin
            cfg_in_h     <= desc_in_h;
            cfg_in_w     <= desc_in_w;
            cfg_in_c     <= desc_in_c;
            cfg_in_base  <= desc_in_base;
            cfg_out_base <= desc_out_base;
            op           <= desc_op;
            state        <= S_CHECK;
          end
          S_CHECK: begin
            if (op_mask == '0) begin
              err_code <= E_BAD_OP;
              state    <= S_ERR;
            end else if (!(|(eng_busy & op_mask))) begin
              state <= S_START;
            end
          end
          S_START: begin
            tmo_cnt <= '0;
            if (spurious) begin
              err_code <= E_SPURIOUS;
              state    <= S_ERR;
            end else if (op_done) begin
              state <= S_NEXT;
            end else begin
              state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (spurious) begin
              err_code <= E_SPURIOUS;
              state    <= S_ERR;
            end else if (op_done) begin
              state <= S_NEXT;
            end else if (tmo_hit) begin
              err_code <= E_TIMEOUT;
              state    <= S_ERR;
            end else if (tmo_cnt != '1) begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          S_NEXT: begin
            if (cur_layer == num_layers - LAYER_W'(1)) begin
              state <= S_DONE;
            end else begin
              cur_layer <= cur_layer + 1'b1;
              state     <= S_FETCH;
            end
          end
          S_DONE: begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
          S_ERR: begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Walks a per-layer descriptor table and runs each layer on one of NUM_ENG compute engines (conv, depthwise, GAP, FC runners).
- For each layer: reads the descriptor, drives the shared cfg bus, pulses the selected engine's start, and waits for that engine's done.
- Sits between the host control registers and the engine bank. Reports progress, completion and error status.

Parameters:
- ADDR_W, 32, activation address width
- DIM_W, 16, tensor dimension width
- NUM_ENG, 4, number of engines, >=2
- ENG_W, 2, engine-select width, >= clog2(NUM_ENG)
- LAYER_W, 8, layer index width
- TMO_W, 24, timeout counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin sequence; ignored while busy
- abort  in  1  stop the sequence and flag an error
- cfg_num_layers  in  LAYER_W  layers to run, latched at start
- cfg_timeout  in  TMO_W  max cycles per layer, 0 = disabled, latched at start
- busy  out  1  state != S_IDLE
- done  out  1  one-cycle pulse at sequence end, success or error
- error  out  1  sticky until next accepted start
- err_code  out  3  0 none, 1 bad op, 2 timeout, 3 spurious done, 4 abort
- cur_layer  out  LAYER_W  index of the layer in progress
- desc_rd_en  out  1  descriptor read strobe
- desc_rd_addr  out  LAYER_W  descriptor index
- desc_op  in  ENG_W  engine select; data valid 1 cycle after desc_rd_en
- desc_in_h, desc_in_w, desc_in_c  in  DIM_W each  layer dimensions
- desc_in_base, desc_out_base  in  ADDR_W each  activation bases
- eng_start  out  NUM_ENG  one-hot start pulse
- eng_busy  in  NUM_ENG  engine busy flags
- eng_done  in  NUM_ENG  engine done pulses
- cfg_in_h, cfg_in_w, cfg_in_c  out  DIM_W each  shared engine config
- cfg_in_base, cfg_out_base  out  ADDR_W each  shared engine config

Behaviour:
- Reset: every output is 0. Internal state goes to S_IDLE and all counters clear. Reset mid-sequence drops everything; no done is issued.
- States:
  - S_IDLE: on start, latch num_layers and timeout, set cur_layer=0, clear error and err_code. Go to S_DONE if num_layers==0, else to S_FETCH.
  - S_FETCH: desc_rd_en=1 combinationally, desc_rd_addr=cur_layer. Go to S_LATCH.
  - S_LATCH: register the desc_* inputs into the cfg_* outputs and an op register. Go to S_CHECK.
  - S_CHECK:
    - op >= NUM_ENG: err_code=1, go to S_ERR.
    - eng_busy[op]=1: stay in S_CHECK. The timeout does not apply here.
    - otherwise go to S_START.
  - S_START: eng_start = one-hot(op) for exactly this cycle. Clear the timeout counter. Go to S_WAIT.
  - S_WAIT:
    - eng_done[op] is checked first and always wins: go to S_NEXT.
    - Otherwise, if timeout!=0 and the counter equals timeout: err_code=2, go to S_ERR.
    - Otherwise increment the counter (saturating).
  - S_NEXT: if cur_layer == num_layers-1, go to S_DONE. Else cur_layer+1 and go to S_FETCH.
  - S_DONE: done<=1 (registered, visible on the next cycle). Go to S_IDLE.
  - S_ERR: error<=1, done<=1. Go to S_IDLE.
- Spurious done: eng_done[k] for any k != op during S_START or S_WAIT sets err_code=3 and goes to S_ERR. This has priority over a simultaneous eng_done[op].
- eng_done[op] arriving during S_START counts as completion; go directly to S_NEXT.
- eng_done pulses in any other state are ignored.
- abort: has top priority in every state except S_IDLE. Sets err_code=4 and goes to S_ERR the next cycle. No further eng_start is issued.
- Stability: cfg_* outputs are held from S_LATCH until the next S_LATCH, and after sequence end until the next layer latch. The engines sample them on eng_start.
- Timing: start accepted at cycle T gives desc_rd_en at T+1, cfg valid at T+3, eng_start at T+4. eng_done[op] at cycle D gives the next desc_rd_en at D+2. For the last layer, done is high at D+3.
- Widths: the counter is TMO_W bits and saturates at all-ones. Layer indices wrap nowhere because num_layers ≤ 2^LAYER_W-1.

Test Plan:
- 3 layers, ops {0,2,1}, engines model done 10 cycles after start -> eng_start one-hot 0001, 0100, 0010 in order. cfg_* match each descriptor. done pulses once; error=0.
- cfg_num_layers=0 -> done high 2 cycles after start. No desc_rd_en, no eng_start.
- desc_op=3 with NUM_ENG=3 -> no eng_start. done and error, err_code=1, cur_layer=0.
- cfg_timeout=5, engine never finishes -> error with err_code=2 after 6 S_WAIT cycles, then done. A later start runs a good sequence with error cleared.
- eng_busy[1]=1 for 20 cycles before layer 0 (op 1) -> eng_start delayed until the cycle after busy drops. Timeout=5 does not fire.
- eng_done[2] pulse while waiting on op 0 -> err_code=3. Separately, abort mid-wait -> err_code=4. Start pulsed while busy -> ignored, sequence unaffected.
